// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer for the stopwatch counter chain.
// Conditions both push-buttons and drives tick, count enable, clear pulse and lap-frozen display digits.
module stopwatch_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  input  logic [3:0] h,
  output logic       tick,
  output logic       count_en,
  output logic       cnt_clr,
  output logic       lap_active,
  output logic [3:0] d_s0,
  output logic [3:0] d_s1,
  output logic [3:0] d_m0,
  output logic [3:0] d_m1,
  output logic [3:0] d_h
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  logic [1:0]    btn_raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    ev_s;
  logic          ss_ev_s;
  logic          lr_ev_s;

  state_t        state_r;
  state_t        state_n;
  logic          clr_req_s;
  logic          lap_load_s;
  logic          counting_s;
  logic          counting_n_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_n;
  logic          por_done_r;
  logic          tick_r;
  logic          count_en_r;
  logic          cnt_clr_r;
  logic          lap_active_r;
  logic [19:0]   lap_r;

  assign btn_raw_s = {btn_lr, btn_ss};

  // Two-flop synchronizer for both raw buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [DW-1:0] deb_cnt_r;
    logic          lvl_r;
    logic          ev_r;

    // Debounce: a new level needs DEB_CYCLES consecutive differing samples; event on the 0->1 acceptance
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        deb_cnt_r <= '0;
        lvl_r     <= 1'b0;
        ev_r      <= 1'b0;
      end else if (sync2_r[i] != lvl_r) begin
        if (deb_cnt_r == DEB_LAST) begin
          deb_cnt_r <= '0;
          lvl_r     <= sync2_r[i];
          ev_r      <= sync2_r[i];
        end else begin
          deb_cnt_r <= deb_cnt_r + DW'(1);
          ev_r      <= 1'b0;
        end
      end else begin
        deb_cnt_r <= '0;
        ev_r      <= 1'b0;
      end
    end

    assign ev_s[i] = ev_r;
  end

  // Start/stop wins when both buttons fire in the same cycle
  assign ss_ev_s = ev_s[0];
  assign lr_ev_s = ev_s[1] & ~ev_s[0];

  // Next-state, clear request and lap capture
  always_comb begin
    state_n    = state_r;
    clr_req_s  = 1'b0;
    lap_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_ev_s) begin
          state_n = RUN;
        end else if (lr_ev_s) begin
          clr_req_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (ss_ev_s) begin
          state_n = PAUSE;
        end else if (lr_ev_s) begin
          state_n    = LAP;
          lap_load_s = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      LAP: begin
        if (ss_ev_s) begin
          state_n = PAUSE;
        end else if (lr_ev_s) begin
          state_n = RUN;
        end else begin
          state_n = LAP;
        end
      end
      PAUSE: begin
        if (ss_ev_s) begin
          state_n = RUN;
        end else if (lr_ev_s) begin
          state_n   = IDLE;
          clr_req_s = 1'b1;
        end else begin
          state_n = PAUSE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Prescaler: cleared in IDLE, held in PAUSE so a partial second survives
  always_comb begin
    counting_s   = (state_r == RUN) || (state_r == LAP);
    counting_n_s = (state_n == RUN) || (state_n == LAP);
    if (state_r == IDLE) begin
      presc_n = '0;
    end else if (counting_s) begin
      if (presc_r == PRESC_LAST) begin
        presc_n = '0;
      end else begin
        presc_n = presc_r + PW'(1);
      end
    end else begin
      presc_n = presc_r;
    end
  end

  // State, prescaler and registered control outputs; por_done_r yields the post-reset clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      presc_r      <= '0;
      por_done_r   <= 1'b0;
      tick_r       <= 1'b0;
      count_en_r   <= 1'b0;
      cnt_clr_r    <= 1'b0;
      lap_active_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      presc_r      <= presc_n;
      por_done_r   <= 1'b1;
      tick_r       <= counting_n_s && (presc_n == PRESC_LAST);
      count_en_r   <= counting_n_s;
      cnt_clr_r    <= clr_req_s | ~por_done_r;
      lap_active_r <= (state_n == LAP);
    end
  end

  // Lap capture of the live digits, held until the next capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_r <= 20'd0;
    end else if (lap_load_s) begin
      lap_r <= {h, m1, m0, s1, s0};
    end else begin
      lap_r <= lap_r;
    end
  end

  assign tick       = tick_r;
  assign count_en   = count_en_r;
  assign cnt_clr    = cnt_clr_r;
  assign lap_active = lap_active_r;
  assign d_s0       = lap_active_r ? lap_r[3:0]   : s0;
  assign d_s1       = lap_active_r ? lap_r[7:4]   : s1;
  assign d_m0       = lap_active_r ? lap_r[11:8]  : m0;
  assign d_m1       = lap_active_r ? lap_r[15:12] : m1;
  assign d_h        = lap_active_r ? lap_r[19:16] : h;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle-level reference model pushes the expected output
// vector each cycle, and an independent negedge monitor pops and compares it.
module tb_stopwatch_ctrl;

  localparam int DIV  = 10;
  localparam int DEB  = 3;
  localparam int NMAX = 8192;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [3:0] s0 = 4'd0, s1 = 4'd0, m0 = 4'd0, m1 = 4'd0, h = 4'd0;
  logic       tick, count_en, cnt_clr, lap_active;
  logic [3:0] d_s0, d_s1, d_m0, d_m1, d_h;

  stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1), .h(h),
    .tick(tick), .count_en(count_en), .cnt_clr(cnt_clr), .lap_active(lap_active),
    .d_s0(d_s0), .d_s1(d_s1), .d_m0(d_m0), .d_m1(d_m1), .d_h(d_h)
  );

  always #5 clk = ~clk;

  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: mode, counting cycles since the last clear, and per-button sample history
  int          mode;
  int          elapsed;
  int          edge_cnt;
  bit          clr_m;
  logic [19:0] lap_m;
  bit          ev_m[2];
  bit          lvl_m[2];
  int          flip_edge[2];
  bit          rawh[2][NMAX];
  bit          smp[2][NMAX];

  task automatic model_reset();
    mode     = M_IDLE;
    elapsed  = 0;
    edge_cnt = 0;
    clr_m    = 1'b0;
    lap_m    = 20'd0;
    for (int b = 0; b < 2; b++) begin
      ev_m[b]      = 1'b0;
      lvl_m[b]     = 1'b0;
      flip_edge[b] = -1;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, predict this cycle's outputs, then advance the model
  task automatic step(input bit ss_v, input bit lr_v, input bit rst_v);
    logic [19:0] dig;
    bit counting, tick_e, nclr, used, all_diff;
    int e, nmode;
    @(posedge clk);
    #1;
    dig    = 20'($urandom);
    btn_ss = ss_v;
    btn_lr = lr_v;
    reset  = rst_v;
    {h, m1, m0, s1, s0} = dig;
    cyc++;
    if (!rst_v) model_reset();
    counting = (mode == M_RUN) || (mode == M_LAP);
    tick_e   = counting && ((elapsed % DIV) == DIV - 1);
    exp_q.push_back({tick_e, counting, clr_m, (mode == M_LAP), (mode == M_LAP) ? lap_m : dig});
    if (rst_v && edge_cnt < NMAX) begin
      e = edge_cnt;
      rawh[0][e] = ss_v;
      rawh[1][e] = lr_v;
      nmode = mode;
      nclr  = (e == 0);
      if (ev_m[0]) begin
        nmode = (mode == M_IDLE || mode == M_PAUSE) ? M_RUN : M_PAUSE;
      end else if (ev_m[1]) begin
        if (mode == M_IDLE) nclr = 1'b1;
        else if (mode == M_RUN) begin nmode = M_LAP; lap_m = dig; end
        else if (mode == M_LAP) nmode = M_RUN;
        else begin nmode = M_IDLE; nclr = 1'b1; end
      end
      if (mode == M_IDLE) elapsed = 0;
      else if (counting) elapsed++;
      for (int b = 0; b < 2; b++) begin
        used      = (e >= 2) ? rawh[b][e-2] : 1'b0;
        smp[b][e] = used;
        ev_m[b]   = 1'b0;
        if (e - flip_edge[b] >= DEB) begin
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++) if (smp[b][e-k] == lvl_m[b]) all_diff = 1'b0;
          if (all_diff) begin
            lvl_m[b]     = ~lvl_m[b];
            flip_edge[b] = e;
            ev_m[b]      = lvl_m[b];
          end
        end
      end
      mode  = nmode;
      clr_m = nclr;
      edge_cnt++;
    end
  endtask

  task automatic hold(input bit ss_v, input bit lr_v, input int n);
    repeat (n) step(ss_v, lr_v, 1'b1);
  endtask

  // Monitor: every cycle presents a full output vector
  always @(negedge clk) begin : monitor
    logic [23:0] act, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      act  = {tick, count_en, cnt_clr, lap_active, d_h, d_m1, d_m0, d_s1, d_s0};
      n_checks++;
      if (act !== want) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %h expected %h ({tick,en,clr,lap,h,m1,m0,s1,s0})",
                 cyc, act, want);
      end
    end
  end

  initial begin : driver
    bit ss_v, lr_v, rst_v;
    int ss_left, lr_left;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 50);
    hold(1'b1, 1'b0, 1);  hold(1'b0, 1'b0, 6);
    hold(1'b1, 1'b0, 2);  hold(1'b0, 1'b0, 6);
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 25);
    hold(1'b0, 1'b1, 5);  hold(1'b0, 1'b0, 20);
    hold(1'b0, 1'b1, 5);  hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b0, 5);  hold(1'b0, 1'b0, 15);
    hold(1'b1, 1'b0, 5);  hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b0, 5);  hold(1'b0, 1'b0, 8);
    hold(1'b0, 1'b1, 5);  hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 5);  hold(1'b0, 1'b0, 8);
    hold(1'b1, 1'b1, 5);  hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 5);  hold(1'b0, 1'b0, 8);
    hold(1'b0, 1'b1, 5);  hold(1'b0, 1'b0, 6);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 10);
    // Random button activity with occasional reset pulses
    ss_v = 1'b0; lr_v = 1'b0; ss_left = 0; lr_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ss_left == 0) begin ss_v = 1'($urandom_range(0, 1)); ss_left = $urandom_range(1, 12); end
      if (lr_left == 0) begin lr_v = 1'($urandom_range(0, 1)); lr_left = $urandom_range(1, 12); end
      rst_v = ($urandom_range(0, 399) != 0);
      step(ss_v, lr_v, rst_v);
      ss_left--;
      lr_left--;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
